// File: rtl/dp_ram_arb_if.sv
// rtl/dp_ram_arb_if.sv - requester-side bus between engine clients and the dual-port RAM arbiter
//
// Signals (one bit or slice per requester, slice i = requester i):
//   req        client -> arb  command valid, held until granted
//   req_we     client -> arb  1 = write, 0 = read
//   req_add    client -> arb  RAM address, add_wd bits per requester
//   req_wdata  client -> arb  write data, data_wd bits per requester
//   gnt        arb -> client  command accepted this cycle
//   rvalid     arb -> client  read data valid
//   rdata      arb -> client  read data, zero when rvalid is low
// Modports: master = engine client side, slave = arbiter side.
interface dp_ram_arb_if #(
    parameter int NREQ    = 4,
    parameter int add_wd  = 4,
    parameter int data_wd = 32
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         req_we;
    logic [NREQ*add_wd-1:0]  req_add;
    logic [NREQ*data_wd-1:0] req_wdata;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         rvalid;
    logic [NREQ*data_wd-1:0] rdata;

    modport master (
        output req, req_we, req_add, req_wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, req_we, req_add, req_wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dp_ram_arb.sv
// rtl/dp_ram_arb.sv - round-robin arbiter sharing both ports of a dual-port RAM among NREQ requesters
//
// Ports:
//   clk                        clock, all state on rising edge
//   rst                        asynchronous active-low reset
//   req_if (slave)             requester bus: req/req_we/req_add/req_wdata in, gnt/rvalid/rdata out
//   ram_cs                     RAM chip select (any grant this cycle)
//   ram_rd0/1, ram_wr0/1       RAM port read/write strobes
//   ram_rd_add0/1, ram_wr_add0/1  RAM port addresses
//   ram_wr_data0/1             RAM port write data
//   ram_rd_data0/1             RAM read data, valid the cycle after the read strobe
//
// Each cycle the first requester found from rr_ptr onward takes port 0 and the
// next one takes port 1. A second write to the same address as the first is
// held back one cycle so the RAM never sees a write-write collision.
module dp_ram_arb #(
    parameter int NREQ    = 4,
    parameter int add_wd  = 4,
    parameter int data_wd = 32
) (
    input  logic               clk,
    input  logic               rst,
    dp_ram_arb_if.slave        req_if,
    output logic               ram_cs,
    output logic               ram_rd0,
    output logic               ram_rd1,
    output logic               ram_wr0,
    output logic               ram_wr1,
    output logic [add_wd-1:0]  ram_rd_add0,
    output logic [add_wd-1:0]  ram_rd_add1,
    output logic [add_wd-1:0]  ram_wr_add0,
    output logic [add_wd-1:0]  ram_wr_add1,
    output logic [data_wd-1:0] ram_wr_data0,
    output logic [data_wd-1:0] ram_wr_data1,
    input  logic [data_wd-1:0] ram_rd_data0,
    input  logic [data_wd-1:0] ram_rd_data1
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [1:0]         tag_v_q, tag_v_d;
    logic [IDX_W-1:0]   tag_id_q [2];
    logic [IDX_W-1:0]   tag_id_d [2];

    logic               a_found, b_found;
    logic [IDX_W-1:0]   a_idx, b_idx, scan_idx;
    logic               a_we, b_we;
    logic [add_wd-1:0]  a_add, b_add;
    logic [data_wd-1:0] a_wdata, b_wdata;
    logic               a_go, b_go;
    logic [NREQ-1:0]    gnt_c;
    logic [NREQ-1:0]    rvalid_c;
    logic [NREQ*data_wd-1:0] rdata_c;

    // Rotating scan: the first two requesting indices at or after rr_ptr.
    always_comb begin
        a_found  = 1'b0;
        b_found  = 1'b0;
        a_idx    = '0;
        b_idx    = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = IDX_W'((int'(rr_ptr_q) + k) % NREQ);
            if (req_if.req[scan_idx]) begin
                if (!a_found) begin
                    a_found = 1'b1;
                    a_idx   = scan_idx;
                end else if (!b_found) begin
                    b_found = 1'b1;
                    b_idx   = scan_idx;
                end
            end
        end
    end

    assign a_we    = req_if.req_we[a_idx];
    assign b_we    = req_if.req_we[b_idx];
    assign a_add   = req_if.req_add[a_idx*add_wd +: add_wd];
    assign b_add   = req_if.req_add[b_idx*add_wd +: add_wd];
    assign a_wdata = req_if.req_wdata[a_idx*data_wd +: data_wd];
    assign b_wdata = req_if.req_wdata[b_idx*data_wd +: data_wd];

    // Nothing is granted while reset is low, so no command reaches the RAM.
    assign a_go = rst & a_found;
    assign b_go = rst & b_found & ~(a_we & b_we & (a_add == b_add));

    always_comb begin
        gnt_c = '0;
        if (a_go) gnt_c[a_idx] = 1'b1;
        if (b_go) gnt_c[b_idx] = 1'b1;
    end

    assign req_if.gnt = gnt_c;

    assign ram_cs       = a_go | b_go;
    assign ram_rd0      = a_go & ~a_we;
    assign ram_wr0      = a_go & a_we;
    assign ram_rd_add0  = a_add;
    assign ram_wr_add0  = a_add;
    assign ram_wr_data0 = a_wdata;
    assign ram_rd1      = b_go & ~b_we;
    assign ram_wr1      = b_go & b_we;
    assign ram_rd_add1  = b_add;
    assign ram_wr_add1  = b_add;
    assign ram_wr_data1 = b_wdata;

    // Next scan starts just past the last index served; a blocked B therefore
    // becomes the first candidate next cycle.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (b_go) begin
            rr_ptr_d = IDX_W'((int'(b_idx) + 1) % NREQ);
        end else if (a_go) begin
            rr_ptr_d = IDX_W'((int'(a_idx) + 1) % NREQ);
        end
    end

    // One tag per RAM port remembers who owns the read data arriving next cycle.
    always_comb begin
        tag_v_d     = {b_go & ~b_we, a_go & ~a_we};
        tag_id_d[0] = a_idx;
        tag_id_d[1] = b_idx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            tag_v_q     <= '0;
            tag_id_q[0] <= '0;
            tag_id_q[1] <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            tag_v_q     <= tag_v_d;
            tag_id_q[0] <= tag_id_d[0];
            tag_id_q[1] <= tag_id_d[1];
        end
    end

    // A requester is granted at most once per cycle, so the two tags never
    // target the same slice.
    always_comb begin
        rvalid_c = '0;
        rdata_c  = '0;
        if (tag_v_q[0]) begin
            rvalid_c[tag_id_q[0]]                     = 1'b1;
            rdata_c[tag_id_q[0]*data_wd +: data_wd]   = ram_rd_data0;
        end
        if (tag_v_q[1]) begin
            rvalid_c[tag_id_q[1]]                     = 1'b1;
            rdata_c[tag_id_q[1]*data_wd +: data_wd]   = ram_rd_data1;
        end
    end

    assign req_if.rvalid = rvalid_c;
    assign req_if.rdata  = rdata_c;
endmodule

// File: tb/tb_dp_ram_arb.sv
// tb/tb_dp_ram_arb.sv - self-checking bench for dp_ram_arb with a behavioural RAM and reference model
module tb_dp_ram_arb;
    localparam int N  = 4;
    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dp_ram_arb_if #(.NREQ(N), .add_wd(AW), .data_wd(DW)) bus ();

    logic          ram_cs, ram_rd0, ram_rd1, ram_wr0, ram_wr1;
    logic [AW-1:0] ram_rd_add0, ram_rd_add1, ram_wr_add0, ram_wr_add1;
    logic [DW-1:0] ram_wr_data0, ram_wr_data1, ram_rd_data0, ram_rd_data1;

    dp_ram_arb #(.NREQ(N), .add_wd(AW), .data_wd(DW)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .req_if       (bus),
        .ram_cs       (ram_cs),
        .ram_rd0      (ram_rd0),
        .ram_rd1      (ram_rd1),
        .ram_wr0      (ram_wr0),
        .ram_wr1      (ram_wr1),
        .ram_rd_add0  (ram_rd_add0),
        .ram_rd_add1  (ram_rd_add1),
        .ram_wr_add0  (ram_wr_add0),
        .ram_wr_add1  (ram_wr_add1),
        .ram_wr_data0 (ram_wr_data0),
        .ram_wr_data1 (ram_wr_data1),
        .ram_rd_data0 (ram_rd_data0),
        .ram_rd_data1 (ram_rd_data1)
    );

    // Behavioural dual-port RAM: registered read, read sees pre-write contents.
    logic [DW-1:0] mem [16];
    logic [DW-1:0] rq0, rq1;
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) mem[i] <= '0;
        end else if (ram_cs) begin
            if (ram_rd0) rq0 <= mem[ram_rd_add0];
            if (ram_rd1) rq1 <= mem[ram_rd_add1];
            if (ram_wr0) mem[ram_wr_add0] <= ram_wr_data0;
            if (ram_wr1) mem[ram_wr_add1] <= ram_wr_data1;
        end
    end
    assign ram_rd_data0 = rq0;
    assign ram_rd_data1 = rq1;

    // Reference model state
    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_ptr    = 0;
    logic [N-1:0]  exp_rv   = '0;
    logic [DW-1:0] exp_rd   [N];
    logic [DW-1:0] ref_mem  [16];
    logic [N-1:0]  last_gnt = '0;
    int            wait_cnt [N];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] f_add(input int i);
        return bus.req_add[i*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] f_wd(input int i);
        return bus.req_wdata[i*DW +: DW];
    endfunction

    task automatic set_cmd(input int i, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]              = 1'b1;
        bus.req_we[i]           = we;
        bus.req_add[i*AW +: AW] = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic drop();
        for (int i = 0; i < N; i++) if (last_gnt[i]) bus.req[i] = 1'b0;
    endtask

    task automatic clear_model();
        m_ptr  = 0;
        exp_rv = '0;
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    endtask

    // One clock cycle: check outputs at the falling edge against the model,
    // then advance the model across the rising edge.
    task automatic step();
        int q[$];
        int a, b;
        logic [N-1:0]    eg;
        logic [N*DW-1:0] erd;
        logic [N-1:0]    nrv;
        logic [DW-1:0]   nrd [N];
        @(negedge clk);
        q = {};
        for (int k = 0; k < N; k++) begin
            int i = (m_ptr + k) % N;
            if (bus.req[i]) q.push_back(i);
        end
        eg = '0; a = -1; b = -1;
        if (rst_n && q.size() > 0) begin
            a = q[0];
            eg[a] = 1'b1;
            if (q.size() > 1) begin
                b = q[1];
                if (bus.req_we[a] && bus.req_we[b] && f_add(a) == f_add(b)) b = -1;
                else eg[b] = 1'b1;
            end
        end
        chk("gnt", bus.gnt, eg);
        chk("ram_cs", ram_cs, |eg);
        if (a < 0) chk("port0_idle", {ram_rd0, ram_wr0}, 2'b00);
        else if (bus.req_we[a]) begin
            chk("port0_wr", {ram_rd0, ram_wr0}, 2'b01);
            chk("port0_wadd", {ram_wr_add0, ram_wr_data0}, {f_add(a), f_wd(a)});
        end else begin
            chk("port0_rd", {ram_rd0, ram_wr0}, 2'b10);
            chk("port0_radd", ram_rd_add0, f_add(a));
        end
        if (b < 0) chk("port1_idle", {ram_rd1, ram_wr1}, 2'b00);
        else if (bus.req_we[b]) begin
            chk("port1_wr", {ram_rd1, ram_wr1}, 2'b01);
            chk("port1_wadd", {ram_wr_add1, ram_wr_data1}, {f_add(b), f_wd(b)});
        end else begin
            chk("port1_rd", {ram_rd1, ram_wr1}, 2'b10);
            chk("port1_radd", ram_rd_add1, f_add(b));
        end
        erd = '0;
        for (int i = 0; i < N; i++) if (exp_rv[i]) erd[i*DW +: DW] = exp_rd[i];
        chk("rvalid", bus.rvalid, exp_rv);
        chk("rdata", bus.rdata, erd);
        for (int i = 0; i < N; i++) begin
            if (rst_n && bus.req[i] && !bus.gnt[i]) wait_cnt[i]++;
            else wait_cnt[i] = 0;
            if (bus.req[i]) begin
                n_assert++;
                assert (wait_cnt[i] <= N) else begin
                    n_fail++;
                    $error("FAIL fairness_%0d: observed wait %0d expected <= %0d", i, wait_cnt[i], N);
                end
            end
        end
        // model update: reads see memory before this cycle's writes
        nrv = '0;
        for (int i = 0; i < N; i++) nrd[i] = '0;
        if (a >= 0 && !bus.req_we[a]) begin nrv[a] = 1'b1; nrd[a] = ref_mem[f_add(a)]; end
        if (b >= 0 && !bus.req_we[b]) begin nrv[b] = 1'b1; nrd[b] = ref_mem[f_add(b)]; end
        if (a >= 0 && bus.req_we[a]) ref_mem[f_add(a)] = f_wd(a);
        if (b >= 0 && bus.req_we[b]) ref_mem[f_add(b)] = f_wd(b);
        if (b >= 0) m_ptr = (b + 1) % N;
        else if (a >= 0) m_ptr = (a + 1) % N;
        last_gnt = eg;
        @(posedge clk);
        #1;
        if (!rst_n) clear_model();
        else begin
            exp_rv = nrv;
            for (int i = 0; i < N; i++) exp_rd[i] = nrd[i];
        end
    endtask

    initial begin
        bus.req = '0; bus.req_we = '0; bus.req_add = '0; bus.req_wdata = '0;
        for (int i = 0; i < N; i++) exp_rd[i] = '0;
        clear_model();

        // Requests during reset must not be granted
        bus.req = 4'b1111;
        step();
        step();
        bus.req = '0;
        rst_n = 1'b1;
        clear_model();

        // Idle cycles
        repeat (5) step();

        // Requester 2: write then read back address 5
        set_cmd(2, 1'b1, 4'd5, 32'hDEADBEEF); step(); drop();
        set_cmd(2, 1'b0, 4'd5, 32'h0);        step(); drop();
        chk("rd_deadbeef", {bus.rvalid[2], bus.rdata[2*DW +: DW]}, {1'b1, 32'hDEADBEEF});
        step();

        // Bring the pointer back to 0, then all four reading for 4 cycles
        set_cmd(3, 1'b0, 4'd0, 32'h0); step(); drop();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i + 8), 32'h0);
        step(); chk("rr_pair0", last_gnt, 4'b0011);
        step(); chk("rr_pair1", last_gnt, 4'b1100);
        step();
        step();
        bus.req = '0;
        step();

        // Same-address write collision
        set_cmd(0, 1'b1, 4'd3, 32'h11);
        set_cmd(1, 1'b1, 4'd3, 32'h22);
        step(); drop();
        step(); drop();
        set_cmd(0, 1'b0, 4'd3, 32'h0); step(); drop();
        chk("collide_final", bus.rdata[0 +: DW], 32'h22);
        step();

        // Read and write to the same address in one cycle
        set_cmd(0, 1'b1, 4'd7, 32'hAA); step(); drop();
        set_cmd(1, 1'b0, 4'd7, 32'h0);
        set_cmd(3, 1'b1, 4'd7, 32'h55);
        step(); drop();
        chk("rw_same_old", bus.rdata[1*DW +: DW], 32'hAA);
        step();

        // Reset pulsed while a read is granted
        set_cmd(1, 1'b0, 4'd2, 32'h0); step(); drop();
        set_cmd(2, 1'b0, 4'd6, 32'h0);
        @(negedge clk);
        chk("rst_pre_gnt", bus.gnt, 4'b0100);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_gnt", {bus.gnt, ram_cs}, 5'b0);
        chk("rst_rvalid", bus.rvalid, 4'b0);
        @(posedge clk);
        #1;
        bus.req = '0;
        rst_n = 1'b1;
        clear_model();
        step();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, AW'(i), 32'h0);
        step(); chk("rst_ptr0", last_gnt, 4'b0011);
        bus.req = '0;
        step();

        // Randomised traffic with hold-until-granted requesters
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req[i] && $urandom_range(0, 1) == 1)
                    set_cmd(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 3)), $urandom);
            end
            step();
            drop();
        end
        bus.req = '0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/dp_ram_arb.md
Name: dp_ram_arb

Overview:
- Round-robin arbiter that shares the two ports of the team's dual-port RAM (two read/write ports, 1-cycle registered read) among NREQ requesters.
- Each cycle it grants up to two requesters: the first winner gets port 0, the second gets port 1.
- Returns each read result to the requester that issued it, and blocks write-write collisions to the same address.
- Sits between the engine clients and the RAM instance.

Parameters:
- NREQ, 4, number of requesters, legal 2..8.
- add_wd, 4, RAM address width.
- data_wd, 32, RAM data width.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester command valid; held until granted.
- req_we  in  NREQ  1 = write, 0 = read.
- req_add  in  NREQ*add_wd  per-requester address; slice i = requester i.
- req_wdata  in  NREQ*data_wd  per-requester write data.
- gnt  out  NREQ  command accepted this cycle (combinational).
- rvalid  out  NREQ  read data valid for requester i.
- rdata  out  NREQ*data_wd  read data per requester; zero when rvalid[i]=0.
- ram_cs  out  1  RAM chip select.
- ram_rd0, ram_rd1, ram_wr0, ram_wr1  out  1 each  RAM port strobes.
- ram_rd_add0, ram_rd_add1, ram_wr_add0, ram_wr_add1  out  add_wd each  RAM addresses.
- ram_wr_data0, ram_wr_data1  out  data_wd each  RAM write data.
- ram_rd_data0, ram_rd_data1  in  data_wd each  RAM read data, valid the cycle after the read strobe.

Behaviour:
- State: rr_ptr (log2 NREQ bits); per port p a tag register {tag_v[p], tag_id[p]}.
- Reset (rst=0, async):
  - rr_ptr=0, tag_v=0, so rvalid=0 and rdata=0.
  - gnt, ram_cs and all RAM strobes forced 0 while rst=0.
  - RAM address/data outputs are don't-care.
- Arbitration (combinational each cycle):
  - Scan indices rr_ptr, rr_ptr+1, ... mod NREQ.
  - First index with req=1 is winner A and goes to port 0.
  - Next index with req=1 is winner B and goes to port 1.
  - Exception: if A and B are both writes to the same address, B is not granted this cycle.
- Command drive:
  - For each granted port p: read asserts ram_rd<p> with ram_rd_add<p>=req_add slice; write asserts ram_wr<p> with ram_wr_add<p>/ram_wr_data<p> from the slices.
  - Unused port: strobes 0.
  - ram_cs = |gnt.
- Pointer update at posedge:
  - Any grant: rr_ptr = (highest-priority-order granted index + 1) mod NREQ, i.e. B+1 if B granted, else A+1.
  - No grant: rr_ptr holds.
- Read return:
  - At the posedge of a granted read on port p: tag_v[p]=1, tag_id[p]=requester index; otherwise tag_v[p]=0.
  - Next cycle: rvalid[tag_id[p]]=1 and rdata slice = ram_rd_data<p>.
  - Latency: exactly 1 cycle from gnt to rvalid.
  - Both ports never return to the same requester in one cycle, since a requester is granted at most once per cycle.
- Write/read ordering:
  - A read and a write to the same address in the same cycle: the read returns the pre-write data.
  - A requester re-issuing back-to-back is allowed: gnt in consecutive cycles is legal.
- Fairness: a continuously requesting requester is granted within ceil(NREQ/2) cycles, or NREQ cycles under sustained same-address write collisions.
- Reset mid-operation: in-flight tags are discarded, and no rvalid follows a read granted in the cycle reset asserts.

Test Plan:
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, ram_cs=0, rvalid=0, rr_ptr stays 0.
- Requester 2 writes addr 5 data 0xDEADBEEF, then reads addr 5 -> writes gnt[2] on port 0 with ram_wr0=1; read returns rvalid[2]=1 and rdata[2]=0xDEADBEEF one cycle after its gnt.
- req=4'b1111, all reads, held 4 cycles -> grants {0,1},{2,3},{0,1},{2,3}; ports 0/1 carry the lower/higher index; each rvalid follows 1 cycle later.
- Requesters 0 and 1 both write addr 3 (data 0x11, 0x22) -> cycle 1 gnt=4'b0001 only; cycle 2 gnt[1]; final read of addr 3 returns 0x22.
- Requester 1 reads addr 7 while requester 3 writes addr 7 with 0x55 (old value 0xAA) in the same cycle -> both granted; rdata[1]=0xAA.
- Read granted, rst pulsed low before the next posedge -> no rvalid afterwards; rr_ptr=0 after release.
